// File: rtl/mmio_pkg.sv
// mmio_pkg
// Shared definitions for the memory-mapped I/O responder: register offsets
// inside the I/O window, STATUS bit positions and a helper that assembles
// the STATUS word from its individual flags.
package mmio_pkg;

  // Register offsets, taken from addr[3:0]
  localparam logic [3:0] OFF_LED    = 4'd0;
  localparam logic [3:0] OFF_SW     = 4'd1;
  localparam logic [3:0] OFF_TIMER  = 4'd2;
  localparam logic [3:0] OFF_STATUS = 4'd3;
  localparam logic [3:0] OFF_TXDATA = 4'd4;

  // STATUS bit positions
  localparam int ST_WRAP  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  // Build the STATUS word; every bit not named here reads as 0
  function automatic logic [15:0] pack_status(input logic wrap,
                                              input logic full,
                                              input logic empty,
                                              input logic ovf);
    logic [15:0] status;
    status           = '0;
    status[ST_WRAP]  = wrap;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF]   = ovf;
    return status;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// io_fifo
// Small synchronous word FIFO used as the TX queue of the I/O responder.
// A push while full is accepted only when a pop happens in the same cycle,
// so the occupancy never exceeds DEPTH. The head word reads as 0 while the
// FIFO is empty so the consumer never sees stale data.
//
// Ports:
//   clk      in  1      clock
//   reset    in  1      synchronous, active-low
//   i_push   in  1      write i_din at the tail
//   i_din    in  WIDTH  data to push
//   i_pop    in  1      remove the head word
//   o_dout   out WIDTH  head word (0 when empty)
//   o_full   out 1      DEPTH words stored
//   o_empty  out 1      no words stored
module io_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  // DEPTH is a power of two, so pointer overflow gives the mod-DEPTH wrap
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder
// Memory-mapped I/O responder sitting beside the BRAM on the CPU load/store
// port. Accesses whose address falls in the 16-word window at IO_BASE are
// served from local registers (LED, synchronized switches, free-running
// timer, STATUS, TX FIFO) and are kept away from the BRAM write enable.
// Load data is registered so it arrives with the same one-cycle latency as
// a BRAM read; o_rd_sel tells the datapath to take o_rdata for that load.
//
// Ports:
//   clk         in  1   clock
//   reset       in  1   synchronous, active-low
//   i_mem_en    in  1   CPU memory access strobe
//   i_mem_we    in  1   CPU store request
//   i_addr      in  16  access address
//   i_wdata     in  16  store data
//   o_ram_we    out 1   BRAM write enable, I/O stores removed (combinational)
//   o_rdata     out 16  registered I/O read data
//   o_rd_sel    out 1   registered: current load is served from o_rdata
//   o_led       out 16  LED register
//   i_sw_in     in  16  asynchronous switch inputs
//   o_tx_data   out 16  TX FIFO head word
//   o_tx_valid  out 1   TX FIFO non-empty
//   i_tx_ready  in  1   consumer accepts the head word
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [15:0] IO_BASE    = 16'hF000,
  parameter int          PRESCALE   = 50000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_mem_en,
  input  logic        i_mem_we,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic        o_ram_we,
  output logic [15:0] o_rdata,
  output logic        o_rd_sel,
  output logic [15:0] o_led,
  input  logic [15:0] i_sw_in,
  output logic [15:0] o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [15:0]   r_led;
  logic [15:0]   r_timer;
  logic [PW-1:0] r_prescale;
  logic          r_wrap;
  logic          r_ovf;
  logic [15:0]   r_sw_meta;
  logic [15:0]   r_sw_sync;
  logic [15:0]   r_rdata;
  logic          r_rd_sel;

  logic          w_hit;
  logic [3:0]    w_off;
  logic          w_store;
  logic          w_load;
  logic          w_led_wr;
  logic          w_timer_wr;
  logic          w_tx_wr;
  logic          w_status_rd;
  logic          w_tick;
  logic          w_wrap_set;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_ovf_set;
  logic [15:0]   w_rd_val;

  // Address decode: only the upper 12 bits select the window
  assign w_hit       = (i_addr[15:4] == IO_BASE[15:4]);
  assign w_off       = i_addr[3:0];
  assign w_store     = i_mem_en & i_mem_we & w_hit;
  assign w_load      = i_mem_en & ~i_mem_we & w_hit;
  assign w_led_wr    = w_store & (w_off == OFF_LED);
  assign w_timer_wr  = w_store & (w_off == OFF_TIMER);
  assign w_tx_wr     = w_store & (w_off == OFF_TXDATA);
  assign w_status_rd = w_load & (w_off == OFF_STATUS);

  // I/O stores must never reach the BRAM
  assign o_ram_we = i_mem_we & ~w_hit;

  // Timer tick and wrap detection; a TIMER store suppresses both
  assign w_tick     = (r_prescale == PW'(PRESCALE - 1));
  assign w_wrap_set = w_tick & ~w_timer_wr & (r_timer == 16'hFFFF);

  // TX queue handshake; a push into a full queue is only lost if nothing pops
  assign w_pop     = o_tx_valid & i_tx_ready;
  assign w_push    = w_tx_wr & (~w_full | w_pop);
  assign w_ovf_set = w_tx_wr & w_full & ~w_pop;

  io_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (i_wdata),
    .i_pop   (w_pop),
    .o_dout  (o_tx_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_tx_valid = ~w_empty;

  // Read mux over the current register values; WO and unmapped offsets read 0
  always_comb begin
    w_rd_val = '0;
    case (w_off)
      OFF_LED:    w_rd_val = r_led;
      OFF_SW:     w_rd_val = r_sw_sync;
      OFF_TIMER:  w_rd_val = r_timer;
      OFF_STATUS: w_rd_val = pack_status(r_wrap, w_full, w_empty, r_ovf);
      default:    w_rd_val = '0;
    endcase
  end

  // Two-flop synchronizer for the switch inputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= i_sw_in;
      r_sw_sync <= r_sw_meta;
    end
  end

  // LED register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_led <= '0;
    end else if (w_led_wr) begin
      r_led <= i_wdata;
    end
  end

  // Prescaler and timer; a store reloads the timer and restarts the prescaler
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_timer    <= '0;
      r_prescale <= '0;
    end else if (w_timer_wr) begin
      r_timer    <= i_wdata;
      r_prescale <= '0;
    end else if (w_tick) begin
      r_timer    <= r_timer + 16'd1;
      r_prescale <= '0;
    end else begin
      r_prescale <= r_prescale + PW'(1);
    end
  end

  // Sticky flags: a STATUS read clears them, but a set in the same cycle wins
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_wrap <= w_wrap_set | (r_wrap & ~w_status_rd);
      r_ovf  <= w_ovf_set | (r_ovf & ~w_status_rd);
    end
  end

  // Registered load response; rdata holds across misses and idle cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata  <= '0;
      r_rd_sel <= 1'b0;
    end else begin
      r_rd_sel <= w_load;
      if (w_load) begin
        r_rdata <= w_rd_val;
      end
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rd_sel = r_rd_sel;
  assign o_led    = r_led;

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder
// Self-checking bench for mmio_responder: a directed vector table, short
// hand-written sequences for multi-cycle behaviour (timer wrap, switch
// synchronizer, reset in mid-operation) and a randomized phase compared
// cycle by cycle against a queue-based reference model.
module tb_mmio_responder;

  localparam int PRESCALE = 2;
  localparam int DEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memEn = 1'b0;
  logic        memWe = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [15:0] wdata = 16'h0;
  logic [15:0] swIn = 16'h0;
  logic        txReady = 1'b0;

  logic        ramWe;
  logic [15:0] rdata;
  logic        rdSel;
  logic [15:0] led;
  logic [15:0] txData;
  logic        txValid;

  int errCount = 0;
  int checkCount = 0;

  // Reference model state
  logic [15:0] mLed;
  logic [15:0] mTimer;
  int          mPre;
  logic        mWrap;
  logic        mOvf;
  logic [15:0] mFifo[$];
  logic [15:0] mSync1;
  logic [15:0] mSync2;
  logic [15:0] mRdata;
  logic        mRdSel;

  typedef struct {
    logic        rst;
    logic        en;
    logic        we;
    logic [15:0] a;
    logic [15:0] d;
    logic        tr;
    logic        expRamWe;
    logic [15:0] expLed;
    logic [15:0] expRdata;
    logic        expRdSel;
    logic        expTxValid;
    logic [15:0] expTxData;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mmio_responder #(
    .IO_BASE    (16'hF000),
    .PRESCALE   (PRESCALE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_mem_en   (memEn),
    .i_mem_we   (memWe),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_ram_we   (ramWe),
    .o_rdata    (rdata),
    .o_rd_sel   (rdSel),
    .o_led      (led),
    .i_sw_in    (swIn),
    .o_tx_data  (txData),
    .o_tx_valid (txValid),
    .i_tx_ready (txReady)
  );

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock edge of the reference model, from the inputs present at the edge
  function automatic void modelStep();
    logic        hit;
    logic [3:0]  off;
    logic        load;
    logic        store;
    logic        pop;
    logic        wasFull;
    logic        wrapEv;
    logic        ovfEv;
    logic [15:0] rv;
    hit = (addr[15:4] == 12'hF00);
    off = addr[3:0];
    if (!reset) begin
      mLed = 0; mTimer = 0; mPre = 0; mWrap = 0; mOvf = 0;
      mFifo.delete();
      mSync1 = 0; mSync2 = 0; mRdata = 0; mRdSel = 0;
      return;
    end
    load  = memEn && !memWe && hit;
    store = memEn && memWe && hit;
    case (off)
      4'd0:    rv = mLed;
      4'd1:    rv = mSync2;
      4'd2:    rv = mTimer;
      4'd3:    rv = {12'h000, mOvf, (mFifo.size() == 0), (mFifo.size() == DEPTH), mWrap};
      default: rv = 16'h0000;
    endcase
    wrapEv = 0;
    ovfEv  = 0;
    if (store && off == 4'd2) begin
      mTimer = wdata;
      mPre   = 0;
    end else if (mPre == PRESCALE - 1) begin
      mPre = 0;
      if (mTimer == 16'hFFFF) wrapEv = 1;
      mTimer = mTimer + 16'd1;
    end else begin
      mPre = mPre + 1;
    end
    wasFull = (mFifo.size() == DEPTH);
    pop = (mFifo.size() > 0) && txReady;
    if (pop) void'(mFifo.pop_front());
    if (store && off == 4'd4) begin
      if (!wasFull || pop) mFifo.push_back(wdata);
      else ovfEv = 1;
    end
    mWrap = wrapEv | (mWrap & !(load && off == 4'd3));
    mOvf  = ovfEv  | (mOvf  & !(load && off == 4'd3));
    if (store && off == 4'd0) mLed = wdata;
    if (load) mRdata = rv;
    mRdSel = load;
    mSync2 = mSync1;
    mSync1 = swIn;
  endfunction

  task automatic checkOutput(input string tag);
    checkVal({tag, " led"}, led, mLed);
    checkVal({tag, " rdata"}, rdata, mRdata);
    checkVal({tag, " rd_sel"}, {15'h0, rdSel}, {15'h0, mRdSel});
    checkVal({tag, " tx_valid"}, {15'h0, txValid}, {15'h0, mFifo.size() > 0});
    checkVal({tag, " tx_data"}, txData, (mFifo.size() > 0) ? mFifo[0] : 16'h0000);
  endtask

  // Called at a falling edge: drive, check ram_we, clock once, check the rest
  task automatic applyStimulus(input logic r, input logic en, input logic we,
                               input logic [15:0] a, input logic [15:0] d,
                               input logic tr, input string tag,
                               output logic seenRamWe);
    reset = r; memEn = en; memWe = we; addr = a; wdata = d; txReady = tr;
    #1;
    seenRamWe = ramWe;
    checkVal({tag, " ram_we"}, {15'h0, ramWe}, {15'h0, we & (a[15:4] != 12'hF00)});
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput(tag);
  endtask

  function automatic void addVec(input logic en, input logic we, input logic [15:0] a,
                                 input logic [15:0] d, input logic tr, input logic eRw,
                                 input logic [15:0] eLed, input logic [15:0] eRd,
                                 input logic eSel, input logic eV, input logic [15:0] eD);
    vec_t v;
    v.rst = 1; v.en = en; v.we = we; v.a = a; v.d = d; v.tr = tr;
    v.expRamWe = eRw; v.expLed = eLed; v.expRdata = eRd; v.expRdSel = eSel;
    v.expTxValid = eV; v.expTxData = eD;
    vecs.push_back(v);
  endfunction

  initial begin
    logic rw;
    logic [15:0] rAddr;
    logic [15:0] rData;

    // Directed vectors: LED, non-I/O access, FIFO fill/overflow/drain,
    // push+pop at full, unmapped and read-only offsets
    addVec(1, 1, 16'hF000, 16'hA5A5, 0, 0, 16'hA5A5, 16'h0000, 0, 0, 16'h0000);
    addVec(1, 0, 16'hF000, 16'h0000, 0, 0, 16'hA5A5, 16'hA5A5, 1, 0, 16'h0000);
    addVec(1, 1, 16'h0123, 16'h1234, 0, 1, 16'hA5A5, 16'hA5A5, 0, 0, 16'h0000);
    addVec(1, 0, 16'h0123, 16'h0000, 0, 0, 16'hA5A5, 16'hA5A5, 0, 0, 16'h0000);
    for (int i = 1; i <= 5; i++)
      addVec(1, 1, 16'hF004, 16'(i), 0, 0, 16'hA5A5, 16'hA5A5, 0, 1, 16'h0001);
    addVec(1, 0, 16'hF003, 16'h0000, 0, 0, 16'hA5A5, 16'h000A, 1, 1, 16'h0001);
    addVec(1, 0, 16'hF003, 16'h0000, 0, 0, 16'hA5A5, 16'h0002, 1, 1, 16'h0001);
    addVec(0, 0, 16'h0000, 16'h0000, 1, 0, 16'hA5A5, 16'h0002, 0, 1, 16'h0002);
    addVec(0, 0, 16'h0000, 16'h0000, 1, 0, 16'hA5A5, 16'h0002, 0, 1, 16'h0003);
    addVec(0, 0, 16'h0000, 16'h0000, 1, 0, 16'hA5A5, 16'h0002, 0, 1, 16'h0004);
    addVec(0, 0, 16'h0000, 16'h0000, 1, 0, 16'hA5A5, 16'h0002, 0, 0, 16'h0000);
    addVec(1, 0, 16'hF003, 16'h0000, 0, 0, 16'hA5A5, 16'h0004, 1, 0, 16'h0000);
    addVec(1, 1, 16'hF004, 16'h0006, 0, 0, 16'hA5A5, 16'h0004, 0, 1, 16'h0006);
    addVec(1, 1, 16'hF004, 16'h0007, 0, 0, 16'hA5A5, 16'h0004, 0, 1, 16'h0006);
    addVec(1, 1, 16'hF004, 16'h0008, 0, 0, 16'hA5A5, 16'h0004, 0, 1, 16'h0006);
    addVec(1, 1, 16'hF004, 16'h000A, 0, 0, 16'hA5A5, 16'h0004, 0, 1, 16'h0006);
    addVec(1, 1, 16'hF004, 16'h0009, 1, 0, 16'hA5A5, 16'h0004, 0, 1, 16'h0007);
    addVec(1, 0, 16'hF003, 16'h0000, 0, 0, 16'hA5A5, 16'h0002, 1, 1, 16'h0007);
    addVec(0, 0, 16'h0000, 16'h0000, 1, 0, 16'hA5A5, 16'h0002, 0, 1, 16'h0008);
    addVec(0, 0, 16'h0000, 16'h0000, 1, 0, 16'hA5A5, 16'h0002, 0, 1, 16'h000A);
    addVec(0, 0, 16'h0000, 16'h0000, 1, 0, 16'hA5A5, 16'h0002, 0, 1, 16'h0009);
    addVec(0, 0, 16'h0000, 16'h0000, 1, 0, 16'hA5A5, 16'h0002, 0, 0, 16'h0000);
    addVec(1, 0, 16'hF007, 16'h0000, 0, 0, 16'hA5A5, 16'h0000, 1, 0, 16'h0000);
    addVec(1, 1, 16'hF001, 16'hFFFF, 0, 0, 16'hA5A5, 16'h0000, 0, 0, 16'h0000);
    addVec(1, 0, 16'hF001, 16'h0000, 0, 0, 16'hA5A5, 16'h0000, 1, 0, 16'h0000);
    addVec(1, 1, 16'hF003, 16'hFFFF, 0, 0, 16'hA5A5, 16'h0000, 0, 0, 16'h0000);
    addVec(1, 0, 16'hF003, 16'h0000, 0, 0, 16'hA5A5, 16'h0004, 1, 0, 16'h0000);
    addVec(1, 0, 16'hF000, 16'h0000, 0, 0, 16'hA5A5, 16'hA5A5, 1, 0, 16'h0000);

    // Reset state
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000, 0, "reset0", rw);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000, 0, "reset1", rw);
    checkVal("reset led", led, 16'h0000);
    checkVal("reset rdata", rdata, 16'h0000);
    checkVal("reset rd_sel", {15'h0, rdSel}, 16'h0000);
    checkVal("reset tx_valid", {15'h0, txValid}, 16'h0000);
    checkVal("reset tx_data", txData, 16'h0000);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].we, vecs[i].a, vecs[i].d,
                    vecs[i].tr, tag, rw);
      checkVal({tag, " tbl ram_we"}, {15'h0, rw}, {15'h0, vecs[i].expRamWe});
      checkVal({tag, " tbl led"}, led, vecs[i].expLed);
      checkVal({tag, " tbl rdata"}, rdata, vecs[i].expRdata);
      checkVal({tag, " tbl rd_sel"}, {15'h0, rdSel}, {15'h0, vecs[i].expRdSel});
      checkVal({tag, " tbl tx_valid"}, {15'h0, txValid}, {15'h0, vecs[i].expTxValid});
      checkVal({tag, " tbl tx_data"}, txData, vecs[i].expTxData);
    end

    // Timer wrap: FFFE, two ticks of PRESCALE=2 cycles each reach 0 and set WRAP
    applyStimulus(1, 1, 1, 16'hF002, 16'hFFFE, 0, "wrap store", rw);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 0, 16'h0000, 16'h0000, 0, "wrap idle", rw);
    applyStimulus(1, 1, 0, 16'hF002, 16'h0000, 0, "wrap timer", rw);
    checkVal("wrap timer value", rdata, 16'h0000);
    applyStimulus(1, 1, 0, 16'hF003, 16'h0000, 0, "wrap status1", rw);
    checkVal("wrap status first read", rdata, 16'h0005);
    applyStimulus(1, 1, 0, 16'hF003, 16'h0000, 0, "wrap status2", rw);
    checkVal("wrap status second read", rdata, 16'h0004);

    // Switch synchronizer: new value visible on the third consecutive load
    swIn = 16'hBEEF;
    applyStimulus(1, 1, 0, 16'hF001, 16'h0000, 0, "sw0", rw);
    checkVal("sw after 1 edge", rdata, 16'h0000);
    applyStimulus(1, 1, 0, 16'hF001, 16'h0000, 0, "sw1", rw);
    checkVal("sw after 2 edges", rdata, 16'h0000);
    applyStimulus(1, 1, 0, 16'hF001, 16'h0000, 0, "sw2", rw);
    checkVal("sw synchronized", rdata, 16'hBEEF);

    // Reset in mid-operation with queued words, LED set and a load pending
    applyStimulus(1, 1, 1, 16'hF004, 16'h0011, 0, "rst push1", rw);
    applyStimulus(1, 1, 1, 16'hF004, 16'h0022, 0, "rst push2", rw);
    applyStimulus(1, 1, 1, 16'hF000, 16'h00FF, 0, "rst led", rw);
    checkVal("pre-reset led", led, 16'h00FF);
    applyStimulus(0, 1, 0, 16'hF000, 16'h0000, 0, "rst edge", rw);
    checkVal("mid reset tx_valid", {15'h0, txValid}, 16'h0000);
    checkVal("mid reset led", led, 16'h0000);
    checkVal("mid reset rd_sel", {15'h0, rdSel}, 16'h0000);
    checkVal("mid reset rdata", rdata, 16'h0000);
    applyStimulus(1, 1, 0, 16'hF002, 16'h0000, 0, "rst timer", rw);
    checkVal("post reset timer", rdata, 16'h0000);
    checkVal("post reset rd_sel", {15'h0, rdSel}, 16'h0001);

    // Randomized phase against the reference model
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 9) < 7) rAddr = {12'hF00, 4'($urandom_range(0, 7))};
      else rAddr = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rData = 16'hFFFF;
        1:       rData = 16'hFFFE;
        default: rData = 16'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) swIn = 16'($urandom);
      applyStimulus(($urandom_range(0, 149) != 0), 1'($urandom), 1'($urandom),
                    rAddr, rData, 1'($urandom_range(0, 2) == 0), "rand", rw);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
